// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel compare timer with shared prescaler and masked irq
//
// Purpose: up to four compare channels count on a shared prescaler tick. Each
// channel runs one-shot or periodic, raises a sticky match flag (write 1 to
// clear), and the flags are masked by IRQ_EN into a registered level irq.
//
// Optional feature: define MULTI_TIMER_PRESCALER_EN to build the programmable
// prescaler. Without it the tick is constant 1 and PRESCALE reads 0.
//
// Ports:
//   CLK       in   1             system clock, rising edge
//   RSTb      in   1             asynchronous active-low reset
//   ADDRESS   in   ADDRESS_BITS  register select
//   DATA_IN   in   BITS          write data
//   DATA_OUT  out  BITS          registered read data (1-cycle latency)
//   WR        in   1             write strobe
//   irq       out  1             registered OR of (STATUS & IRQ_EN)
//
// Register map: 0x0 STATUS, 0x1 IRQ_EN, 0x2 PRESCALE, 0x3 reserved,
//   0x4+3n CTRLn {PERIODIC, ENABLE}, 0x5+3n CMPn, 0x6+3n CNTn.

module multi_timer #(
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 4,
    parameter int CHANNELS      = 2,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    output logic                    irq
);

    localparam logic [ADDRESS_BITS-1:0] ADDR_STATUS   = ADDRESS_BITS'(0);
    localparam logic [ADDRESS_BITS-1:0] ADDR_IRQ_EN   = ADDRESS_BITS'(1);
    localparam logic [ADDRESS_BITS-1:0] ADDR_PRESCALE = ADDRESS_BITS'(2);

    logic [CHANNELS-1:0] status;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] periodic;
    logic [CHANNELS-1:0] match_set;
    logic [BITS-1:0]     cmp [CHANNELS];
    logic [BITS-1:0]     cnt [CHANNELS];

    logic                tick;
    logic [BITS-1:0]     prescale_rd;
    logic                wr_status;
    logic                wr_irq_en;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_cmp;
    logic [CHANNELS-1:0] wr_cnt;
    logic [BITS-1:0]     rd_data;

    // Write decode; channel addresses beyond CHANNELS never match and are ignored.
    always_comb begin
        wr_status = WR && (ADDRESS == ADDR_STATUS);
        wr_irq_en = WR && (ADDRESS == ADDR_IRQ_EN);
        wr_ctrl   = '0;
        wr_cmp    = '0;
        wr_cnt    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            wr_ctrl[n] = WR && (ADDRESS == ADDRESS_BITS'(4 + 3 * n));
            wr_cmp[n]  = WR && (ADDRESS == ADDRESS_BITS'(5 + 3 * n));
            wr_cnt[n]  = WR && (ADDRESS == ADDRESS_BITS'(6 + 3 * n));
        end
    end

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] pc;
    logic                     wr_prescale;

    assign wr_prescale = WR && (ADDRESS == ADDR_PRESCALE);
    assign tick        = (pc == prescale);
    assign prescale_rd = BITS'(prescale);

    // pc runs continuously 0..P; a PRESCALE write restarts the divide phase.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            prescale <= '0;
            pc       <= '0;
        end else if (wr_prescale) begin
            prescale <= DATA_IN[PRESCALE_BITS-1:0];
            pc       <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end
`else
    assign tick        = 1'b1;
    assign prescale_rd = '0;
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic            en_r;
        logic            per_r;
        logic [BITS-1:0] cmp_r;
        logic [BITS-1:0] cnt_r;
        logic            advance;
        logic            hit;

        // A bus write to CTRL or CNT in a tick cycle takes priority over counting.
        assign advance      = tick && en_r && !wr_ctrl[n] && !wr_cnt[n];
        assign hit          = (cnt_r == cmp_r);
        assign match_set[n] = advance && hit;

        assign enable[n]   = en_r;
        assign periodic[n] = per_r;
        assign cmp[n]      = cmp_r;
        assign cnt[n]      = cnt_r;

        always_ff @(posedge CLK or negedge RSTb) begin
            if (!RSTb) begin
                en_r  <= 1'b0;
                per_r <= 1'b0;
                cmp_r <= '0;
                cnt_r <= '0;
            end else begin
                if (wr_ctrl[n]) begin
                    en_r  <= DATA_IN[0];
                    per_r <= DATA_IN[1];
                end else if (match_set[n] && !per_r) begin
                    en_r <= 1'b0;
                end

                if (wr_cmp[n]) begin
                    cmp_r <= DATA_IN;
                end

                if (wr_cnt[n]) begin
                    cnt_r <= DATA_IN;
                end else if (advance) begin
                    if (hit) begin
                        // One-shot holds the matched count; periodic restarts at 0.
                        if (per_r) begin
                            cnt_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
            end
        end
    end

    // Read mux: unmapped and absent-channel addresses return 0.
    always_comb begin
        rd_data = '0;
        if (ADDRESS == ADDR_STATUS) begin
            rd_data = BITS'(status);
        end else if (ADDRESS == ADDR_IRQ_EN) begin
            rd_data = BITS'(irq_en);
        end else if (ADDRESS == ADDR_PRESCALE) begin
            rd_data = prescale_rd;
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (ADDRESS == ADDRESS_BITS'(4 + 3 * n)) begin
                rd_data = BITS'({periodic[n], enable[n]});
            end else if (ADDRESS == ADDRESS_BITS'(5 + 3 * n)) begin
                rd_data = cmp[n];
            end else if (ADDRESS == ADDRESS_BITS'(6 + 3 * n)) begin
                rd_data = cnt[n];
            end
        end
    end

    // A match set on the same edge as a W1C of that bit leaves the flag set.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            status   <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
            DATA_OUT <= '0;
        end else begin
            status   <= (status & ~(wr_status ? DATA_IN[CHANNELS-1:0] : '0)) | match_set;
            if (wr_irq_en) begin
                irq_en <= DATA_IN[CHANNELS-1:0];
            end
            irq      <= |(status & irq_en);
            DATA_OUT <= rd_data;
        end
    end

endmodule
